dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port data memory between the MIPS core data port and a debug/loader port. The debug port is used by the bench or a future DMA or program loader. It sits between mips_core/data_mem and the debug master, and replaces the direct core-to-memory wiring. It performs round-robin arbitration with a bounded burst length and a debug lock, and counts core stall cycles for performance debug.

Parameters:
DATA_WIDTH, 32, data bus width (matches DATA_MEM_WIDTH)
ADDR_WIDTH, 32, address bus width
MAX_BURST, 4, max consecutive grants to one requester while the other is waiting (>=1)
CNT_WIDTH, 16, width of the saturating core-stall counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
core_req  in  1  core requests a memory access this cycle
core_we  in  1  core access is a write
core_addr  in  ADDR_WIDTH  core address
core_wdata  in  DATA_WIDTH  core write data
core_gnt  out  1  core access performed this cycle
core_rdata  out  DATA_WIDTH  read data to core
dbg_req  in  1  debug port requests an access
dbg_we  in  1  debug access is a write
dbg_addr  in  ADDR_WIDTH  debug address
dbg_wdata  in  DATA_WIDTH  debug write data
dbg_lock  in  1  debug holds ownership (no preemption) while asserted
dbg_gnt  out  1  debug access performed this cycle
dbg_rdata  out  DATA_WIDTH  read data to debug
mem_we  out  1  to data_mem write_en
mem_addr  out  ADDR_WIDTH  to data_mem address
mem_wdata  out  DATA_WIDTH  to data_mem data_in
mem_rdata  in  DATA_WIDTH  from data_mem data_out (combinational read)
owner  out  2  owner_e of the previous cycle's grant
core_stall_cnt  out  CNT_WIDTH  saturating count of cycles with core_req & !core_gnt

Behaviour:
- Ports: one clock (clk); reset is synchronous and active-high (rst).
- State register owner_e: OWN_NONE, OWN_CORE, OWN_DBG. It holds who was granted last cycle.
- Also registered: last_served (core/dbg) and burst_cnt (1..MAX_BURST).
- Grants are combinational from the state and the requests (zero-latency). At most one grant per cycle.
- Arbitration per cycle:
  - Only one requester active: that requester is granted.
  - Both active, state OWN_DBG and dbg_lock=1: dbg granted regardless of burst_cnt.
  - Both active, state equals a requester and burst_cnt<MAX_BURST: that requester is granted again.
  - Both active, burst limit reached: the other requester is granted.
  - Both active, state OWN_NONE: the requester != last_served is granted.
  - dbg_lock with no dbg_req has no effect.
- Next state:
  - Grant to the same owner as the state: burst_cnt+1, saturating at MAX_BURST.
  - Grant to a different owner: burst_cnt=1, state=new owner, last_served=new owner.
  - No grant: state=OWN_NONE, burst_cnt=0, last_served unchanged.
- Memory mux:
  - mem_* driven from the granted port.
  - No grant: mem_we=0, mem_addr=0, mem_wdata=0.
  - mem_we is asserted only with a grant. The write commits on that rising edge.
- Read data: x_rdata=mem_rdata when x_gnt=1, else 0. Same cycle as the grant.
- Ungranted requester must hold req/we/addr/wdata stable until granted. The core treats core_req & !core_gnt as a pipeline stall.
- core_stall_cnt: +1 on each cycle with core_req & !core_gnt. Saturates at all-ones and never wraps.
- While rst=1:
  - core_gnt=dbg_gnt=0, mem_we=0, rdata outputs 0.
  - Next edge: state OWN_NONE, burst_cnt=0, last_served=dbg (first tie goes to core), core_stall_cnt=0.
- Reset mid-burst aborts ownership immediately. No memory write occurs in any cycle with rst=1.

Decomposition:
- mips_pkg gains typedef enum logic[1:0] owner_e {OWN_NONE, OWN_CORE, OWN_DBG} and localparam DMEM_MAX_BURST=4.
- DATA_WIDTH/ADDR_WIDTH default from DATA_MEM_WIDTH.
- No sub-module is required. The saturating counter stays inline; it is small enough not to warrant its own module.

Test Plan:
- Reset: rst=1 for 2 cycles with both reqs high, dbg_we=1 -> both gnts 0, mem_we 0, no memory change. After release with core_req only -> core_gnt=1 the same cycle, owner=OWN_CORE next cycle.
- Contention, MAX_BURST=4: both req held 16 cycles from idle -> grants CCCCDDDDCCCCDDDD; core_stall_cnt=8.
- Lock: dbg owns, dbg_lock=1 for 10 cycles with core_req high -> core_gnt=0 for all 10, core_stall_cnt+10. Lock drops with burst_cnt=MAX_BURST -> core_gnt=1 the next cycle.
- Data path: dbg writes 0xDEADBEEF to 0x10 (core idle). Core then reads 0x10 -> core_rdata=0xDEADBEEF in the grant cycle; dbg_rdata=0.
- Reset mid-burst: rst asserted on the 2nd cycle of a core burst with dbg waiting -> state OWN_NONE, counters 0; first tie after release goes to core.
- Saturation, CNT_WIDTH=4: core blocked 20 cycles by dbg_lock -> core_stall_cnt reaches 15 and stays 15.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter between the core data port and the debug port.
package dmem_arbiter_pkg;

  localparam int DATA_MEM_WIDTH = 32;
  localparam int DMEM_MAX_BURST = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the core and a debug/loader master,
// with bounded bursts, a debug ownership lock and a saturating core-stall counter.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_MEM_WIDTH,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = DMEM_MAX_BURST,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_gnt,
  output logic [DATA_WIDTH-1:0] core_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  input  logic                  dbg_lock,
  output logic                  dbg_gnt,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            owner,
  output logic [CNT_WIDTH-1:0]  core_stall_cnt
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  owner_e        state;
  logic [BW-1:0] burst_cnt;
  logic          last_dbg;

  function automatic logic [BW-1:0] burst_inc(input logic [BW-1:0] cnt);
    return (cnt >= BURST_MAX) ? BURST_MAX : cnt + BW'(1);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] stall_inc(input logic [CNT_WIDTH-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
  endfunction

  // Grant decision: combinational from registered ownership and current requests.
  always_comb begin
    core_gnt = 1'b0;
    dbg_gnt  = 1'b0;
    if (!rst) begin
      if (core_req && !dbg_req) begin
        core_gnt = 1'b1;
      end else if (dbg_req && !core_req) begin
        dbg_gnt = 1'b1;
      end else if (core_req && dbg_req) begin
        case (state)
          OWN_DBG: begin
            if (dbg_lock || (burst_cnt < BURST_MAX)) dbg_gnt = 1'b1;
            else core_gnt = 1'b1;
          end
          OWN_CORE: begin
            if (burst_cnt < BURST_MAX) core_gnt = 1'b1;
            else dbg_gnt = 1'b1;
          end
          default: begin
            // Idle tie: serve whoever was not served most recently.
            if (last_dbg) core_gnt = 1'b1;
            else dbg_gnt = 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_gnt) begin
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  assign core_rdata = core_gnt ? mem_rdata : '0;
  assign dbg_rdata  = dbg_gnt  ? mem_rdata : '0;
  assign owner      = state;

  // Ownership, burst and stall-counter update at the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= OWN_NONE;
      burst_cnt      <= '0;
      last_dbg       <= 1'b1;
      core_stall_cnt <= '0;
    end else begin
      if (core_req && !core_gnt) core_stall_cnt <= stall_inc(core_stall_cnt);
      if (core_gnt) begin
        if (state == OWN_CORE) begin
          burst_cnt <= burst_inc(burst_cnt);
        end else begin
          state     <= OWN_CORE;
          burst_cnt <= BW'(1);
          last_dbg  <= 1'b0;
        end
      end else if (dbg_gnt) begin
        if (state == OWN_DBG) begin
          burst_cnt <= burst_inc(burst_cnt);
        end else begin
          state     <= OWN_DBG;
          burst_cnt <= BW'(1);
          last_dbg  <= 1'b1;
        end
      end else begin
        state     <= OWN_NONE;
        burst_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, contention, lock, data path, mid-burst reset and counter saturation.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, dbg_req, dbg_we, dbg_lock;
  logic [31:0] core_addr, core_wdata, dbg_addr, dbg_wdata;
  logic        core_gnt, dbg_gnt, mem_we;
  logic [31:0] core_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  owner;
  logic [15:0] core_stall_cnt;

  logic        s_core_gnt, s_dbg_gnt, s_mem_we;
  logic [31:0] s_core_rdata, s_dbg_rdata, s_mem_addr, s_mem_wdata;
  logic [1:0]  s_owner;
  logic [3:0]  s_stall_cnt;

  logic [31:0] mem [256];

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner(owner), .core_stall_cnt(core_stall_cnt)
  );

  dmem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST(4), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(s_core_gnt), .core_rdata(s_core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(s_dbg_gnt), .dbg_rdata(s_dbg_rdata),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata),
    .owner(s_owner), .core_stall_cnt(s_stall_cnt)
  );

  // Combinational-read memory model, written on the clock edge.
  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_lock = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    next_cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'hA5A5_A5A5;
    mem[8'h20] = 32'h1111_1111;
    idle_inputs();
    rst = 1; core_req = 1; dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h5555_5555;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests++;
      if ({core_gnt, dbg_gnt, mem_we} !== 3'b000) begin
        failed++; $display("FAIL reset_gnt cycle %0d: got gnt/we=%b required 000", c, {core_gnt, dbg_gnt, mem_we});
      end
      tests++;
      if (core_rdata !== 32'h0 || dbg_rdata !== 32'h0) begin
        failed++; $display("FAIL reset_rdata: got core=%h dbg=%h required 0", core_rdata, dbg_rdata);
      end
      next_cycle();
    end
    tests++;
    if (mem[8'h20] !== 32'h1111_1111) begin
      failed++; $display("FAIL reset_nowrite: got mem[0x20]=%h required 11111111", mem[8'h20]);
    end
    tests++;
    if (owner !== OWN_NONE || core_stall_cnt !== 16'd0) begin
      failed++; $display("FAIL reset_state: got owner=%0d cnt=%0d required 0/0", owner, core_stall_cnt);
    end
    rst = 0; dbg_req = 0; dbg_we = 0;
    @(negedge clk);
    tests++;
    if (core_gnt !== 1'b1) begin
      failed++; $display("FAIL reset_release_gnt: got core_gnt=%b required 1", core_gnt);
    end
    next_cycle();
    tests++;
    if (owner !== OWN_CORE) begin
      failed++; $display("FAIL reset_release_owner: got owner=%0d required %0d", owner, OWN_CORE);
    end
  endtask

  task automatic test_contention();
    logic [15:0] exp_core;
    logic [15:0] got_core;
    do_reset();
    exp_core = 16'b1111_0000_1111_0000; // bit 15 = first cycle: CCCCDDDDCCCCDDDD
    got_core = '0;
    core_req = 1; dbg_req = 1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      got_core[15-c] = core_gnt;
      tests++;
      if ((core_gnt ^ dbg_gnt) !== 1'b1) begin
        failed++; $display("FAIL contention_onehot cycle %0d: got core=%b dbg=%b required exactly one", c, core_gnt, dbg_gnt);
      end
      next_cycle();
    end
    tests++;
    if (got_core !== exp_core) begin
      failed++; $display("FAIL contention_pattern: got %b required %b", got_core, exp_core);
    end
    tests++;
    if (core_stall_cnt !== 16'd8) begin
      failed++; $display("FAIL contention_stall: got %0d required 8", core_stall_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    int blocked;
    do_reset();
    dbg_req = 1; dbg_lock = 1;
    next_cycle();
    core_req = 1;
    blocked = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (core_gnt === 1'b0 && dbg_gnt === 1'b1) blocked++;
      next_cycle();
    end
    tests++;
    if (blocked !== 10) begin
      failed++; $display("FAIL lock_hold: got %0d blocked cycles required 10", blocked);
    end
    tests++;
    if (core_stall_cnt !== 16'd10) begin
      failed++; $display("FAIL lock_stall: got %0d required 10", core_stall_cnt);
    end
    dbg_lock = 0;
    @(negedge clk);
    tests++;
    if (core_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin
      failed++; $display("FAIL lock_release: got core=%b dbg=%b required 1/0", core_gnt, dbg_gnt);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_datapath();
    do_reset();
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h10; dbg_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    tests++;
    if (dbg_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEAD_BEEF) begin
      failed++; $display("FAIL dp_write: got gnt=%b we=%b addr=%h data=%h required 1 1 10 deadbeef",
                         dbg_gnt, mem_we, mem_addr, mem_wdata);
    end
    next_cycle();
    idle_inputs();
    core_req = 1; core_addr = 32'h10;
    @(negedge clk);
    tests++;
    if (core_gnt !== 1'b1 || core_rdata !== 32'hDEAD_BEEF) begin
      failed++; $display("FAIL dp_read: got gnt=%b rdata=%h required 1 deadbeef", core_gnt, core_rdata);
    end
    tests++;
    if (dbg_rdata !== 32'h0 || mem_we !== 1'b0) begin
      failed++; $display("FAIL dp_other: got dbg_rdata=%h mem_we=%b required 0 0", dbg_rdata, mem_we);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk);
    tests++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || core_rdata !== 32'h0) begin
      failed++; $display("FAIL dp_idle: got addr=%h wdata=%h rdata=%h required 0", mem_addr, mem_wdata, core_rdata);
    end
    next_cycle();
  endtask

  task automatic test_reset_midburst();
    do_reset();
    core_req = 1; dbg_req = 1;
    next_cycle();
    rst = 1;
    @(negedge clk);
    tests++;
    if (core_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin
      failed++; $display("FAIL midburst_gnt: got core=%b dbg=%b required 0/0", core_gnt, dbg_gnt);
    end
    next_cycle();
    tests++;
    if (owner !== OWN_NONE || core_stall_cnt !== 16'd0) begin
      failed++; $display("FAIL midburst_state: got owner=%0d cnt=%0d required 0/0", owner, core_stall_cnt);
    end
    rst = 0;
    @(negedge clk);
    tests++;
    if (core_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin
      failed++; $display("FAIL midburst_tie: got core=%b dbg=%b required 1/0", core_gnt, dbg_gnt);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    dbg_req = 1; dbg_lock = 1;
    next_cycle();
    core_req = 1;
    for (int c = 0; c < 16; c++) next_cycle();
    tests++;
    if (s_stall_cnt !== 4'd15) begin
      failed++; $display("FAIL sat_reach: got %0d required 15", s_stall_cnt);
    end
    for (int c = 0; c < 4; c++) next_cycle();
    tests++;
    if (s_stall_cnt !== 4'd15) begin
      failed++; $display("FAIL sat_hold: got %0d required 15", s_stall_cnt);
    end
    tests++;
    if (core_stall_cnt !== 16'd20) begin
      failed++; $display("FAIL sat_wide: got %0d required 20", core_stall_cnt);
    end
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_contention();
    test_lock();
    test_datapath();
    test_reset_midburst();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
